mrd_sink_wr_gen: RTL and testbench
==================================

Name: mrd_sink_wr_gen

Overview:
Parametrised sink-side write-address generator for the mixed-radix DFT bank memory. It accepts a framed sample stream and distributes samples round-robin over NBANK RAM banks with a shared row address. It issues the 3/4-frame and twiddle-start pulses, plus frame-done, length-error and sink-timeout status. It sits between the input stream and the mrd bank RAMs, alongside the top-level mrd FSM.

Parameters:
NBANK, 7, number of RAM banks (2..16)
WADDR, 8, bank row address width
WCNT, 12, frame-length/counter width; must hold NBANK*2^WADDR
DW, 36, sample data width (passed through to RAM)
SINK_ST, 3'd1, fsm encoding of the Sink state
OVT_LIMIT, 2047, Sink-state cycle limit before timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fsm  in  3  top mrd FSM state
frame_len  in  WCNT  points N of next frame; sampled on accepted sop
in_valid  in  1  sample valid
in_sop  in  1  first sample of frame; qualified by in_valid
in_eop  in  1  last sample of frame; qualified by in_valid
in_data  in  DW  sample
wr_en  out  NBANK  one-hot bank write enable; bank 0 = bit NBANK-1
wr_addr  out  WADDR  row address, common to all banks
wr_data  out  DW  registered in_data
sink_3_4  out  1  pulse: 3/4 of frame written
twdl_sop_sink  out  1  pulse: one sample before sink_3_4
sink_done  out  1  pulse: last sample written
len_err  out  1  pulse: framing/length error
overTime  out  1  Sink-state timeout level
cnt_sink  out  WCNT  samples accepted in current frame

Behaviour:
- Reset: all outputs 0; frame inactive; counters 0. Reset mid-frame discards the frame; no further writes until a new sop.
- Frame open: accepted sample (in_valid=1) with in_sop=1. Latch len=frame_len. Legal range: 1..NBANK*2^WADDR. Illegal: len_err pulse, frame stays closed, no write.
- Sample index idx (0-based) = samples accepted since sop. Bank bi = idx mod NBANK; row = idx div NBANK. Tracked with incremental counters: bi wraps NBANK-1 -> 0 and row increments on that wrap. No divider.
- Gaps: in_valid=0 holds all counters. Frame continues; no write issued in that cycle.
- Latency: 1 cycle. The sample accepted in cycle t drives wr_en/wr_addr/wr_data in t+1. wr_en=0 on cycles with no write. wr_data follows in_data regardless of write.
- cnt_sink = idx of the next sample; 0 when idle.
- T34 = (len>>2)+(len>>1), WCNT-bit truncating.
  - sink_3_4 pulses aligned with the write of idx=T34-1; suppressed if T34<2.
  - twdl_sop_sink pulses aligned with the write of idx=T34-2; suppressed if T34<2.
- sink_done pulses aligned with the write of idx=len-1; the frame then closes. in_eop on that sample is expected but not required.
- Early eop (in_eop at idx<len-1): sample written, len_err pulse aligned with it, frame closes, no sink_done.
- sop while frame open: len_err pulse. The old frame is abandoned and the new frame opens in the same cycle: bank 0, row 0, sample written.
- Valid without sop while closed: ignored (no write), len_err pulse.
- Simultaneous sop+eop with len=1: single write, sink_done and no len_err.
- overTime counter: +1 each cycle fsm==SINK_ST, saturates at OVT_LIMIT, cleared to 0 when fsm!=SINK_ST.
  - overTime is a registered (counter==OVT_LIMIT) and stays high while saturated.
  - It clears the cycle after fsm leaves Sink.
- All pulses are exactly 1 cycle wide and registered.

Test Plan:
- NBANK=7, len=28, contiguous valid, sop at idx0, eop at idx27 -> wr_en 1000000,0100000,…,0000001 per row, rows 0..3; twdl_sop_sink with idx19 write; sink_3_4 with idx20 write (T34=21); sink_done with idx27 write; len_err never.
- Same frame with valid low every third cycle -> identical write sequence; wr_en=0 in gap cycles; pulses still aligned to idx19/20/27 writes.
- len=28, eop at idx10 -> len_err with idx10 write, no sink_done, no sink_3_4; following valid without sop -> no writes, len_err per sample.
- sop at idx5 of open frame (new len=14) -> len_err pulse; write goes to bank0 row0; new frame completes with sink_done at idx13, sink_3_4 at idx9 (T34=3+7=10).
- fsm=SINK_ST held 2100 cycles from cycle 0 -> overTime first high at cycle 2048, stays high; fsm->0 -> overTime 0 next cycle. frame_len=0 and frame_len=7*256+1 at sop -> len_err, no writes.
- Assert rst at idx12 of len=28 frame -> all outputs 0 next cycle; resumed valid without sop -> no writes; next sop starts at bank0 row0.

Source files
------------

// File: rtl/mrd_sink_wr_gen.sv
// Sink-side write-address generator for the mixed-radix DFT bank memory.
// Spreads a framed sample stream round-robin over NBANK banks and flags framing events.
module mrd_sink_wr_gen #(
  parameter int         NBANK     = 7,
  parameter int         WADDR     = 8,
  parameter int         WCNT      = 12,
  parameter int         DW        = 36,
  parameter logic [2:0] SINK_ST   = 3'd1,
  parameter int         OVT_LIMIT = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       fsm,
  input  logic [WCNT-1:0]  frame_len,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [DW-1:0]    in_data,
  output logic [NBANK-1:0] wr_en,
  output logic [WADDR-1:0] wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             sink_3_4,
  output logic             twdl_sop_sink,
  output logic             sink_done,
  output logic             len_err,
  output logic             overTime,
  output logic [WCNT-1:0]  cnt_sink
);

  localparam int BW = $clog2(NBANK);
  localparam int OW = $clog2(OVT_LIMIT + 1);
  localparam logic [WCNT:0] MAX_LEN = (WCNT+1)'(NBANK) << WADDR;

  logic             active_q, active_d;
  logic [WCNT-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [BW-1:0]    bi_q, bi_d;
  logic [WADDR-1:0] row_q, row_d;
  logic [OW-1:0]    ovt_q;

  logic             sop_ok, do_wr, is_last, t34_ok, hit34, hit_tw, err, closing;
  logic [WCNT-1:0]  cur_len, cur_idx, t34;
  logic [BW-1:0]    wr_bi;
  logic [WADDR-1:0] wr_row;
  logic [NBANK-1:0] wr_en_d;

  // An accepted sop restarts indexing at bank 0 / row 0 with the new length.
  always_comb begin
    sop_ok  = (frame_len != '0) && ({1'b0, frame_len} <= MAX_LEN);
    cur_len = in_sop ? frame_len : len_q;
    cur_idx = in_sop ? '0 : cnt_q;
    wr_bi   = in_sop ? '0 : bi_q;
    wr_row  = in_sop ? '0 : row_q;
    t34     = (cur_len >> 2) + (cur_len >> 1);
    do_wr   = in_valid && (in_sop ? sop_ok : active_q);
    is_last = (cur_idx == cur_len - WCNT'(1));
    t34_ok  = (t34 >= WCNT'(2));
    hit34   = do_wr && t34_ok && (cur_idx == t34 - WCNT'(1));
    hit_tw  = do_wr && t34_ok && (cur_idx == t34 - WCNT'(2));
    closing = do_wr && (is_last || in_eop);
    err     = in_valid && ((in_sop && (active_q || !sop_ok)) ||
                           (!in_sop && !active_q) ||
                           (do_wr && in_eop && !is_last));
  end

  always_comb begin
    active_d = active_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    bi_d     = bi_q;
    row_d    = row_q;
    if (in_valid && in_sop && !sop_ok) begin
      active_d = 1'b0;
      cnt_d    = '0;
      bi_d     = '0;
      row_d    = '0;
    end else if (closing) begin
      active_d = 1'b0;
      cnt_d    = '0;
      bi_d     = '0;
      row_d    = '0;
    end else if (do_wr) begin
      active_d = 1'b1;
      len_d    = cur_len;
      cnt_d    = cur_idx + WCNT'(1);
      if (wr_bi == BW'(NBANK - 1)) begin
        bi_d  = '0;
        row_d = wr_row + WADDR'(1);
      end else begin
        bi_d  = wr_bi + BW'(1);
        row_d = wr_row;
      end
    end
  end

  // Bank 0 sits in the MSB of the enable vector.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign wr_en_d[NBANK-1-b] = do_wr && (wr_bi == BW'(b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      bi_q          <= '0;
      row_q         <= '0;
      ovt_q         <= '0;
      wr_en         <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      sink_3_4      <= 1'b0;
      twdl_sop_sink <= 1'b0;
      sink_done     <= 1'b0;
      len_err       <= 1'b0;
      overTime      <= 1'b0;
    end else begin
      active_q      <= active_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      bi_q          <= bi_d;
      row_q         <= row_d;
      wr_en         <= wr_en_d;
      wr_addr       <= wr_row;
      wr_data       <= in_data;
      sink_3_4      <= hit34;
      twdl_sop_sink <= hit_tw;
      sink_done     <= do_wr && is_last;
      len_err       <= err;
      if (fsm == SINK_ST) begin
        if (ovt_q != OW'(OVT_LIMIT)) ovt_q <= ovt_q + OW'(1);
      end else begin
        ovt_q <= '0;
      end
      overTime      <= (fsm == SINK_ST) && (ovt_q == OW'(OVT_LIMIT));
    end
  end

  assign cnt_sink = cnt_q;

endmodule

// File: tb/tb_mrd_sink_wr_gen.sv
// Directed bench for mrd_sink_wr_gen (NBANK=7, WADDR=8, WCNT=12, DW=36).
module tb_mrd_sink_wr_gen;
  logic        clk, rst;
  logic [2:0]  fsm;
  logic [11:0] frame_len;
  logic        in_valid, in_sop, in_eop;
  logic [35:0] in_data;
  logic [6:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [35:0] wr_data;
  logic        sink_3_4, twdl_sop_sink, sink_done, len_err, overTime;
  logic [11:0] cnt_sink;

  int          vectors = 0;
  int          miscompares = 0;
  int          seq = 0;
  int          idx, cyc;
  logic [35:0] dat;

  mrd_sink_wr_gen dut (
    .clk(clk), .rst(rst), .fsm(fsm), .frame_len(frame_len),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sink_3_4(sink_3_4), .twdl_sop_sink(twdl_sop_sink), .sink_done(sink_done),
    .len_err(len_err), .overTime(overTime), .cnt_sink(cnt_sink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input cycle, then sample just after the capturing edge.
  task automatic drive(input bit v, input bit s, input bit e, input logic [11:0] fl);
    seq++;
    dat       = 36'h5_A000_0000 + 36'(seq * 7);
    in_valid  = v;
    in_sop    = s;
    in_eop    = e;
    frame_len = fl;
    in_data   = dat;
    @(posedge clk);
    #1;
  endtask

  // flags = {sink_3_4, twdl_sop_sink, sink_done, len_err, overTime}
  task automatic check(input string tag, input logic [6:0] en, input logic [7:0] addr,
                       input bit use_addr, input logic [35:0] d, input logic [4:0] flags,
                       input logic [11:0] cnt);
    logic [67:0] o, e;
    o = {wr_en, (use_addr ? wr_addr : addr), wr_data,
         sink_3_4, twdl_sop_sink, sink_done, len_err, overTime, cnt_sink};
    e = {en, addr, d, flags, cnt};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1; fsm = 3'd0;
    in_valid = 0; in_sop = 0; in_eop = 0; frame_len = '0; in_data = '0;
    drive(0, 0, 0, 12'd0);
    drive(1, 1, 0, 12'd28);
    check("reset", 7'd0, 8'd0, 1, 36'd0, 5'b0, 12'd0);
    rst = 1'b0;

    // Contiguous len=28 frame: T34=21
    for (int i = 0; i < 28; i++) begin
      drive(1, i == 0, i == 27, 12'd28);
      check("t1_frame", 7'b1000000 >> (i % 7), 8'(i / 7), 1, dat,
            {i == 20, i == 19, i == 27, 1'b0, 1'b0}, (i == 27) ? 12'd0 : 12'(i + 1));
    end
    drive(0, 0, 0, 12'd28);
    check("t1_idle", 7'd0, 8'd0, 0, dat, 5'b0, 12'd0);

    // Same frame with every third cycle a gap
    idx = 0; cyc = 0;
    while (idx < 28) begin
      if (cyc % 3 == 2) begin
        drive(0, 0, 0, 12'd28);
        check("t2_gap", 7'd0, 8'd0, 0, dat, 5'b0, 12'(idx));
      end else begin
        drive(1, idx == 0, idx == 27, 12'd28);
        check("t2_frame", 7'b1000000 >> (idx % 7), 8'(idx / 7), 1, dat,
              {idx == 20, idx == 19, idx == 27, 1'b0, 1'b0},
              (idx == 27) ? 12'd0 : 12'(idx + 1));
        idx++;
      end
      cyc++;
    end

    // Early eop at idx10, then orphan samples
    for (int i = 0; i <= 10; i++) begin
      drive(1, i == 0, i == 10, 12'd28);
      check("t3_early_eop", 7'b1000000 >> (i % 7), 8'(i / 7), 1, dat,
            {1'b0, 1'b0, 1'b0, i == 10, 1'b0}, (i == 10) ? 12'd0 : 12'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 12'd28);
      check("t3_orphan", 7'd0, 8'd0, 0, dat, 5'b00010, 12'd0);
    end
    drive(0, 0, 0, 12'd28);
    check("t3_idle", 7'd0, 8'd0, 0, dat, 5'b0, 12'd0);

    // sop at idx5 of an open frame, new len=14 -> T34=10
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 0, 12'd28);
      check("t4_old", 7'b1000000 >> (i % 7), 8'(i / 7), 1, dat, 5'b0, 12'(i + 1));
    end
    drive(1, 1, 0, 12'd14);
    check("t4_resop", 7'b1000000, 8'd0, 1, dat, 5'b00010, 12'd1);
    for (int i = 1; i < 14; i++) begin
      drive(1, 0, i == 13, 12'd14);
      check("t4_new", 7'b1000000 >> (i % 7), 8'(i / 7), 1, dat,
            {i == 9, i == 8, i == 13, 1'b0, 1'b0}, (i == 13) ? 12'd0 : 12'(i + 1));
    end

    // Length boundaries
    drive(1, 1, 0, 12'd0);
    check("t5_len0", 7'd0, 8'd0, 0, dat, 5'b00010, 12'd0);
    drive(1, 1, 0, 12'd1793);
    check("t5_len1793", 7'd0, 8'd0, 0, dat, 5'b00010, 12'd0);
    drive(1, 1, 1, 12'd1);
    check("t5_len1", 7'b1000000, 8'd0, 1, dat, 5'b00100, 12'd0);
    drive(1, 1, 0, 12'd1792);
    check("t5_len1792", 7'b1000000, 8'd0, 1, dat, 5'b0, 12'd1);
    drive(1, 0, 1, 12'd1792);
    check("t5_maxeop", 7'b0100000, 8'd0, 1, dat, 5'b00010, 12'd0);

    // Sink-state timeout
    fsm = 3'd1;
    for (int j = 0; j < 2100; j++) begin
      drive(0, 0, 0, 12'd0);
      if (j == 0 || j == 2046 || j == 2047 || j == 2099)
        check("t5_ovt", 7'd0, 8'd0, 0, dat, {4'b0, j >= 2047}, 12'd0);
    end
    fsm = 3'd0;
    drive(0, 0, 0, 12'd0);
    check("t5_ovt_clr", 7'd0, 8'd0, 0, dat, 5'b0, 12'd0);

    // Reset mid-frame at idx12
    for (int i = 0; i < 12; i++) begin
      drive(1, i == 0, 0, 12'd28);
      check("t6_pre", 7'b1000000 >> (i % 7), 8'(i / 7), 1, dat, 5'b0, 12'(i + 1));
    end
    rst = 1'b1;
    drive(1, 0, 0, 12'd28);
    check("t6_rst", 7'd0, 8'd0, 1, 36'd0, 5'b0, 12'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 12'd28);
      check("t6_nosop", 7'd0, 8'd0, 0, dat, 5'b00010, 12'd0);
    end
    drive(1, 1, 0, 12'd28);
    check("t6_newsop", 7'b1000000, 8'd0, 1, dat, 5'b0, 12'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
